// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Lets two SPI masters (arm, fpga_master) share four SPI target ports
// (0 esp32, 1 sd0, 2 sd1, 3 fpga_slave). Each target has its own owner FSM,
// so the two masters can run at the same time on different targets. SPI data
// lines pass through a grant-gated mux. Ownership is decided on clk_i from
// synchronised copies of the master ssel lines.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on master ssel/sclk (minimum 2)
//   TIMEOUT_CYC  idle-sclk cycles before ownership is revoked (watchdog only)
//
// Optional build macro:
//   SPI_ARB_TIMEOUT_EN  adds a per-target watchdog that revokes ownership
//                       after TIMEOUT_CYC clk cycles without an owner sclk
//                       edge. Without it ownership is held until release and
//                       timeout_o is tied to 0.
//
// Ports:
//   clk_i, n_rst_i                  system clock, synchronous active-low reset
//   arm_sclk_i/mosi_i/ssel_i/tsel_i arm master SPI lines + target select
//   arm_miso_o                      arm master MISO (1 when not granted)
//   fpga_sclk_i/mosi_i/ssel_i/tsel_i fpga_master SPI lines + target select
//   fpga_miso_o                     fpga_master MISO (1 when not granted)
//   tgt_sclk_o/mosi_o/ssel_o[3:0]   target SPI lines, bit n = target n
//   tgt_miso_i[3:0]                 target MISO lines
//   arm_gnt_o, fpga_gnt_o           master owns its selected target
//   busy_o[3:0]                     target n is owned
//   timeout_o[1:0]                  one-cycle revoke pulse (bit0 arm, bit1 fpga)
//
// Handshake: a master pulls ssel low with tsel set, then polls its gnt output
// and starts clocking only once gnt=1. Releasing ssel ends ownership; the
// target then spends one GUARD cycle at idle levels before it can be granted.
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk_i,
    input  logic       n_rst_i,
    input  logic       arm_sclk_i,
    input  logic       arm_mosi_i,
    input  logic       arm_ssel_i,
    input  logic [1:0] arm_tsel_i,
    output logic       arm_miso_o,
    input  logic       fpga_sclk_i,
    input  logic       fpga_mosi_i,
    input  logic       fpga_ssel_i,
    input  logic [1:0] fpga_tsel_i,
    output logic       fpga_miso_o,
    output logic [3:0] tgt_sclk_o,
    output logic [3:0] tgt_mosi_o,
    output logic [3:0] tgt_ssel_o,
    input  logic [3:0] tgt_miso_i,
    output logic       arm_gnt_o,
    output logic       fpga_gnt_o,
    output logic [3:0] busy_o,
    output logic [1:0] timeout_o
);

    // Master index: 0 = arm, 1 = fpga_master.
    localparam int NM = 2;
    localparam int NT = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_ARM  = 2'd1,
        ST_OWN_FPGA = 2'd2,
        ST_GUARD    = 2'd3
    } own_state_t;

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("spi_bus_arbiter: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    // ---------------------------------------------------------------------
    // Request front end: ssel synchronisers, falling-edge detect, tsel latch
    // ---------------------------------------------------------------------
    logic [NM-1:0]          w_ssel_raw;
    logic [1:0]             w_tsel_raw [NM];
    logic [SYNC_STAGES-1:0] r_ssel_sync [NM];
    logic [NM-1:0]          r_ssel_d;
    logic [NM-1:0]          w_ssel_s;
    logic [NM-1:0]          w_fall;
    logic [NM-1:0]          r_pend;
    logic [NM-1:0]          w_req;
    logic [NM-1:0]          w_grant_now;
    logic [NM-1:0]          w_lock;
    logic [1:0]             r_tsel [NM];
    logic [1:0]             w_tsel [NM];

    assign w_ssel_raw    = {fpga_ssel_i, arm_ssel_i};
    assign w_tsel_raw[0] = arm_tsel_i;
    assign w_tsel_raw[1] = fpga_tsel_i;

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            for (int m = 0; m < NM; m++) begin
                r_ssel_sync[m] <= '1;
                r_tsel[m]      <= 2'd0;
            end
            r_ssel_d <= '1;
            r_pend   <= '0;
        end else begin
            for (int m = 0; m < NM; m++) begin
                r_ssel_sync[m] <= {r_ssel_sync[m][SYNC_STAGES-2:0], w_ssel_raw[m]};
                r_tsel[m]      <= w_tsel[m];
            end
            r_ssel_d <= w_ssel_s;
            // Pending survives until granted or the master gives up.
            r_pend   <= w_req & ~w_grant_now;
        end
    end

    always_comb begin
        w_ssel_s = '0;
        w_fall   = '0;
        w_req    = '0;
        for (int m = 0; m < NM; m++) begin
            w_ssel_s[m] = r_ssel_sync[m][SYNC_STAGES-1];
            w_fall[m]   = r_ssel_d[m] & ~w_ssel_s[m];
            // tsel is captured only on the request edge; later changes are ignored.
            w_tsel[m]   = w_fall[m] ? w_tsel_raw[m] : r_tsel[m];
            w_req[m]    = (w_fall[m] | r_pend[m]) & ~w_ssel_s[m] & ~w_lock[m];
        end
    end

    // ---------------------------------------------------------------------
    // Per-target owner FSMs
    // ---------------------------------------------------------------------
    own_state_t r_state [NT];
    own_state_t w_state_nxt [NT];
    logic [NT-1:0] r_prio;      // 0: arm wins next contention, 1: fpga wins
    logic [NT-1:0] w_prio_nxt;
    logic [NT-1:0] w_to;        // watchdog expiry for target n (0 without watchdog)

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            for (int n = 0; n < NT; n++) begin
                r_state[n] <= ST_IDLE;
            end
            r_prio <= '0;
        end else begin
            for (int n = 0; n < NT; n++) begin
                r_state[n] <= w_state_nxt[n];
            end
            r_prio <= w_prio_nxt;
        end
    end

    always_comb begin
        w_grant_now = '0;
        w_prio_nxt  = r_prio;
        for (int n = 0; n < NT; n++) begin
            logic w_a_hit;
            logic w_f_hit;
            w_a_hit        = w_req[0] && (w_tsel[0] == 2'(n));
            w_f_hit        = w_req[1] && (w_tsel[1] == 2'(n));
            w_state_nxt[n] = r_state[n];
            case (r_state[n])
                ST_IDLE: begin
                    if (w_a_hit && w_f_hit) begin
                        // Contention: the priority bit picks, then hands priority over.
                        if (!r_prio[n]) begin
                            w_state_nxt[n] = ST_OWN_ARM;
                            w_prio_nxt[n]  = 1'b1;
                        end else begin
                            w_state_nxt[n] = ST_OWN_FPGA;
                            w_prio_nxt[n]  = 1'b0;
                        end
                    end else if (w_a_hit) begin
                        w_state_nxt[n] = ST_OWN_ARM;
                    end else if (w_f_hit) begin
                        w_state_nxt[n] = ST_OWN_FPGA;
                    end
                end
                ST_OWN_ARM: begin
                    if (w_ssel_s[0] || w_to[n]) begin
                        w_state_nxt[n] = ST_GUARD;
                    end
                end
                ST_OWN_FPGA: begin
                    if (w_ssel_s[1] || w_to[n]) begin
                        w_state_nxt[n] = ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    w_state_nxt[n] = ST_IDLE;
                end
                default: begin
                    w_state_nxt[n] = ST_IDLE;
                end
            endcase
            if (r_state[n] == ST_IDLE && w_state_nxt[n] == ST_OWN_ARM) begin
                w_grant_now[0] = 1'b1;
            end
            if (r_state[n] == ST_IDLE && w_state_nxt[n] == ST_OWN_FPGA) begin
                w_grant_now[1] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Grant-gated SPI mux. Idle/guard targets sit at ssel=1, sclk=0, mosi=1.
    // ---------------------------------------------------------------------
    always_comb begin
        tgt_ssel_o  = '1;
        tgt_sclk_o  = '0;
        tgt_mosi_o  = '1;
        busy_o      = '0;
        arm_gnt_o   = 1'b0;
        fpga_gnt_o  = 1'b0;
        arm_miso_o  = 1'b1;
        fpga_miso_o = 1'b1;
        for (int n = 0; n < NT; n++) begin
            // A target whose watchdog just fired is already treated as released.
            if (r_state[n] == ST_OWN_ARM && !w_to[n]) begin
                busy_o[n]     = 1'b1;
                arm_gnt_o     = 1'b1;
                tgt_ssel_o[n] = arm_ssel_i;
                tgt_sclk_o[n] = arm_sclk_i;
                tgt_mosi_o[n] = arm_mosi_i;
                arm_miso_o    = tgt_miso_i[n];
            end else if (r_state[n] == ST_OWN_FPGA && !w_to[n]) begin
                busy_o[n]     = 1'b1;
                fpga_gnt_o    = 1'b1;
                tgt_ssel_o[n] = fpga_ssel_i;
                tgt_sclk_o[n] = fpga_sclk_i;
                tgt_mosi_o[n] = fpga_mosi_i;
                fpga_miso_o   = tgt_miso_i[n];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Ownership watchdog
    // ---------------------------------------------------------------------
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync [NM];
    logic [NM-1:0]          r_sclk_d;
    logic [NM-1:0]          w_sclk_edge;
    logic [NM-1:0]          r_lock;
    logic [CW-1:0]          r_cnt [NT];

    assign w_lock = r_lock;

    always_comb begin
        w_sclk_edge = '0;
        w_to        = '0;
        timeout_o   = '0;
        for (int m = 0; m < NM; m++) begin
            w_sclk_edge[m] = r_sclk_sync[m][SYNC_STAGES-1] ^ r_sclk_d[m];
        end
        for (int n = 0; n < NT; n++) begin
            w_to[n] = (r_state[n] == ST_OWN_ARM || r_state[n] == ST_OWN_FPGA) &&
                      (r_cnt[n] == CW'(TIMEOUT_CYC));
            if (w_to[n] && r_state[n] == ST_OWN_ARM) begin
                timeout_o[0] = 1'b1;
            end
            if (w_to[n] && r_state[n] == ST_OWN_FPGA) begin
                timeout_o[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            for (int m = 0; m < NM; m++) begin
                r_sclk_sync[m] <= '0;
            end
            r_sclk_d <= '0;
            r_lock   <= '0;
            for (int n = 0; n < NT; n++) begin
                r_cnt[n] <= '0;
            end
        end else begin
            r_sclk_sync[0] <= {r_sclk_sync[0][SYNC_STAGES-2:0], arm_sclk_i};
            r_sclk_sync[1] <= {r_sclk_sync[1][SYNC_STAGES-2:0], fpga_sclk_i};
            for (int m = 0; m < NM; m++) begin
                r_sclk_d[m] <= r_sclk_sync[m][SYNC_STAGES-1];
                // A revoked master stays out until it lets go of ssel.
                if (w_ssel_s[m]) begin
                    r_lock[m] <= 1'b0;
                end else if (timeout_o[m]) begin
                    r_lock[m] <= 1'b1;
                end
            end
            for (int n = 0; n < NT; n++) begin
                // Counter rests at 0 outside ownership, so a grant starts it from 0.
                case (r_state[n])
                    ST_OWN_ARM: begin
                        if (w_sclk_edge[0]) begin
                            r_cnt[n] <= '0;
                        end else if (!w_to[n]) begin
                            r_cnt[n] <= r_cnt[n] + 1'b1;
                        end
                    end
                    ST_OWN_FPGA: begin
                        if (w_sclk_edge[1]) begin
                            r_cnt[n] <= '0;
                        end else if (!w_to[n]) begin
                            r_cnt[n] <= r_cnt[n] + 1'b1;
                        end
                    end
                    default: begin
                        r_cnt[n] <= '0;
                    end
                endcase
            end
        end
    end
`else
    assign w_to      = '0;
    assign w_lock    = '0;
    assign timeout_o = '0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       arm_sclk, arm_mosi, arm_ssel, arm_miso;
    logic [1:0] arm_tsel;
    logic       fpga_sclk, fpga_mosi, fpga_ssel, fpga_miso;
    logic [1:0] fpga_tsel;
    logic [3:0] tgt_sclk, tgt_mosi, tgt_ssel, tgt_miso, busy;
    logic       arm_gnt, fpga_gnt;
    logic [1:0] timeout;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    spi_bus_arbiter dut (
        .clk_i       (clk),
        .n_rst_i     (n_rst),
        .arm_sclk_i  (arm_sclk),
        .arm_mosi_i  (arm_mosi),
        .arm_ssel_i  (arm_ssel),
        .arm_tsel_i  (arm_tsel),
        .arm_miso_o  (arm_miso),
        .fpga_sclk_i (fpga_sclk),
        .fpga_mosi_i (fpga_mosi),
        .fpga_ssel_i (fpga_ssel),
        .fpga_tsel_i (fpga_tsel),
        .fpga_miso_o (fpga_miso),
        .tgt_sclk_o  (tgt_sclk),
        .tgt_mosi_o  (tgt_mosi),
        .tgt_ssel_o  (tgt_ssel),
        .tgt_miso_i  (tgt_miso),
        .arm_gnt_o   (arm_gnt),
        .fpga_gnt_o  (fpga_gnt),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    typedef struct {
        string      name;
        logic       a_ssel, a_sclk, a_mosi;
        logic [1:0] a_tsel;
        logic       f_ssel, f_sclk, f_mosi;
        logic [1:0] f_tsel;
        logic [3:0] miso;
        int         wait_cyc;
        logic       a_gnt, f_gnt;
        logic [3:0] busy, t_ssel, t_sclk, t_mosi;
        logic       a_miso, f_miso;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        arm_ssel  = v.a_ssel;  arm_sclk  = v.a_sclk;  arm_mosi  = v.a_mosi;  arm_tsel  = v.a_tsel;
        fpga_ssel = v.f_ssel;  fpga_sclk = v.f_sclk;  fpga_mosi = v.f_mosi;  fpga_tsel = v.f_tsel;
        tgt_miso  = v.miso;
        if (v.wait_cyc == 0) #1;
        else step(v.wait_cyc);
        chk({v.name, "/arm_gnt"},  {7'd0, arm_gnt},   {7'd0, v.a_gnt});
        chk({v.name, "/fpga_gnt"}, {7'd0, fpga_gnt},  {7'd0, v.f_gnt});
        chk({v.name, "/busy"},     {4'd0, busy},      {4'd0, v.busy});
        chk({v.name, "/tgt_ssel"}, {4'd0, tgt_ssel},  {4'd0, v.t_ssel});
        chk({v.name, "/tgt_sclk"}, {4'd0, tgt_sclk},  {4'd0, v.t_sclk});
        chk({v.name, "/tgt_mosi"}, {4'd0, tgt_mosi},  {4'd0, v.t_mosi});
        chk({v.name, "/arm_miso"}, {7'd0, arm_miso},  {7'd0, v.a_miso});
        chk({v.name, "/fpga_miso"},{7'd0, fpga_miso}, {7'd0, v.f_miso});
        chk({v.name, "/timeout"},  {6'd0, timeout},   8'd0);
    endtask

    task automatic idle_masters();
        arm_ssel  = 1'b1; arm_sclk  = 1'b0; arm_mosi  = 1'b1; arm_tsel  = 2'd0;
        fpga_ssel = 1'b1; fpga_sclk = 1'b0; fpga_mosi = 1'b1; fpga_tsel = 2'd0;
        tgt_miso  = 4'hF;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] tx, rx_pat, mosi_cap, miso_cap, sclk_seen;
        logic       got;

        //                 name            a: ssel sclk mosi tsel   f: ssel sclk mosi tsel   miso  wait  agnt fgnt busy  tssel tsclk tmosi amiso fmiso
        vecs.push_back('{"reset_idle",   1'b1,1'b0,1'b1,2'd0, 1'b1,1'b0,1'b1,2'd0, 4'hF, 0, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"arm_req_2clk", 1'b0,1'b0,1'b1,2'd1, 1'b1,1'b0,1'b1,2'd0, 4'hF, 2, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"arm_grant",    1'b0,1'b0,1'b1,2'd1, 1'b1,1'b0,1'b1,2'd0, 4'hD, 1, 1'b1,1'b0,4'h2,4'hD,4'h0,4'hF,1'b0,1'b1});
        vecs.push_back('{"arm_pass",     1'b0,1'b1,1'b0,2'd3, 1'b1,1'b0,1'b1,2'd0, 4'h2, 0, 1'b1,1'b0,4'h2,4'hD,4'h2,4'hD,1'b1,1'b1});
        vecs.push_back('{"arm_raw_rel",  1'b1,1'b0,1'b1,2'd3, 1'b1,1'b0,1'b1,2'd0, 4'h2, 0, 1'b1,1'b0,4'h2,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"arm_rel_sync", 1'b1,1'b0,1'b1,2'd3, 1'b1,1'b0,1'b1,2'd0, 4'h2, 2, 1'b1,1'b0,4'h2,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"arm_guard",    1'b1,1'b0,1'b1,2'd3, 1'b1,1'b0,1'b1,2'd0, 4'h2, 1, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"dual_grant",   1'b0,1'b0,1'b1,2'd0, 1'b0,1'b0,1'b1,2'd3, 4'h8, 3, 1'b1,1'b1,4'h9,4'h6,4'h0,4'hF,1'b0,1'b1});
        vecs.push_back('{"dual_x1",      1'b0,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b1,2'd3, 4'h1, 0, 1'b1,1'b1,4'h9,4'h6,4'h1,4'hE,1'b1,1'b0});
        vecs.push_back('{"dual_x2",      1'b0,1'b0,1'b1,2'd0, 1'b0,1'b1,1'b0,2'd3, 4'h8, 0, 1'b1,1'b1,4'h9,4'h6,4'h8,4'h7,1'b0,1'b1});
        vecs.push_back('{"dual_rel",     1'b1,1'b0,1'b1,2'd0, 1'b1,1'b0,1'b1,2'd3, 4'hF, 2, 1'b1,1'b1,4'h9,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"dual_guard",   1'b1,1'b0,1'b1,2'd0, 1'b1,1'b0,1'b1,2'd3, 4'hF, 1, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"cont1",        1'b0,1'b0,1'b1,2'd2, 1'b0,1'b0,1'b1,2'd2, 4'hB, 3, 1'b1,1'b0,4'h4,4'hB,4'h0,4'hF,1'b0,1'b1});
        vecs.push_back('{"cont1_rel",    1'b1,1'b0,1'b1,2'd2, 1'b0,1'b0,1'b1,2'd2, 4'hB, 2, 1'b1,1'b0,4'h4,4'hF,4'h0,4'hF,1'b0,1'b1});
        vecs.push_back('{"cont1_guard",  1'b1,1'b0,1'b1,2'd2, 1'b0,1'b0,1'b1,2'd2, 4'hB, 1, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"cont1_idle",   1'b1,1'b0,1'b1,2'd2, 1'b0,1'b0,1'b1,2'd2, 4'hB, 1, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"cont1_fpga",   1'b1,1'b0,1'b1,2'd2, 1'b0,1'b0,1'b1,2'd2, 4'hB, 1, 1'b0,1'b1,4'h4,4'hB,4'h0,4'hF,1'b1,1'b0});
        vecs.push_back('{"fpga_rel",     1'b1,1'b0,1'b1,2'd2, 1'b1,1'b0,1'b1,2'd2, 4'hB, 2, 1'b0,1'b1,4'h4,4'hF,4'h0,4'hF,1'b1,1'b0});
        vecs.push_back('{"fpga_guard",   1'b1,1'b0,1'b1,2'd2, 1'b1,1'b0,1'b1,2'd2, 4'hB, 1, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"cont2",        1'b0,1'b0,1'b1,2'd2, 1'b0,1'b0,1'b1,2'd2, 4'hB, 3, 1'b0,1'b1,4'h4,4'hB,4'h0,4'hF,1'b1,1'b0});
        vecs.push_back('{"cont2_rel",    1'b1,1'b0,1'b1,2'd2, 1'b1,1'b0,1'b1,2'd2, 4'hF, 3, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});
        vecs.push_back('{"settle",       1'b1,1'b0,1'b1,2'd2, 1'b1,1'b0,1'b1,2'd2, 4'hF, 2, 1'b0,1'b0,4'h0,4'hF,4'h0,4'hF,1'b1,1'b1});

        // Clock/reset
        idle_masters();
        n_rst = 1'b0;
        step(3);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Byte transfer on sd0: 0xA5 out on MOSI, 0x3C back on MISO.
        tx = 8'hA5; rx_pat = 8'h3C;
        mosi_cap = 8'h00; miso_cap = 8'h00; sclk_seen = 8'h00;
        arm_tsel = 2'd1;
        arm_ssel = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1);
            got = arm_gnt;
        end
        chk("byte/gnt_poll", {7'd0, got}, 8'd1);
        for (int b = 7; b >= 0; b--) begin
            arm_mosi    = tx[b];
            tgt_miso    = 4'hF;
            tgt_miso[1] = rx_pat[b];
            arm_sclk    = 1'b0;
            step(1);
            arm_sclk = 1'b1;
            #1;
            mosi_cap  = {mosi_cap[6:0], tgt_mosi[1]};
            miso_cap  = {miso_cap[6:0], arm_miso};
            sclk_seen = {sclk_seen[6:0], tgt_sclk[1]};
            step(1);
        end
        arm_sclk = 1'b0;
        chk("byte/mosi", mosi_cap, 8'hA5);
        chk("byte/miso", miso_cap, 8'h3C);
        chk("byte/sclk", sclk_seen, 8'hFF);
        chk("byte/others_idle", {4'd0, tgt_ssel}, 8'h0D);
        arm_ssel = 1'b1; arm_mosi = 1'b1; tgt_miso = 4'hF;
        step(5);
        chk("byte/released", {6'd0, arm_gnt, fpga_gnt}, 8'd0);

        // Contention on fpga_slave leaves its priority with fpga, then reset mid-byte.
        arm_tsel = 2'd3; fpga_tsel = 2'd3;
        arm_ssel = 1'b0; fpga_ssel = 1'b0;
        step(3);
        chk("rst/pre_gnt", {6'd0, arm_gnt, fpga_gnt}, 8'b10);
        arm_sclk = 1'b1; arm_mosi = 1'b0;
        #1;
        chk("rst/pre_sclk", {4'd0, tgt_sclk}, 8'h08);
        n_rst = 1'b0;
        step(1);
        chk("rst/ssel", {4'd0, tgt_ssel}, 8'h0F);
        chk("rst/sclk", {4'd0, tgt_sclk}, 8'h00);
        chk("rst/mosi", {4'd0, tgt_mosi}, 8'h0F);
        chk("rst/gnt",  {6'd0, arm_gnt, fpga_gnt}, 8'd0);
        chk("rst/busy", {4'd0, busy}, 8'h00);
        chk("rst/arm_miso", {7'd0, arm_miso}, 8'd1);
        idle_masters();
        step(2);
        n_rst = 1'b1;
        step(3);
        arm_tsel = 2'd3; fpga_tsel = 2'd3;
        arm_ssel = 1'b0; fpga_ssel = 1'b0;
        step(2);
        chk("rst/prio_2clk", {6'd0, arm_gnt, fpga_gnt}, 8'd0);
        step(1);
        chk("rst/prio_arm", {6'd0, arm_gnt, fpga_gnt}, 8'b10);
        chk("rst/prio_busy", {4'd0, busy}, 8'h08);
        idle_masters();
        step(5);
        chk("end/idle", {4'd0, busy}, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
